// File: rtl/grain_stream_decryptor.sv
// grain_stream_decryptor: serial Grain-keystream decryptor with byte assembly.
// A frame is: seed load, WARMUP discarded keystream bits, then msg_len bytes
// recovered MSB-first from the serial ciphertext with a valid/ready handshake.
// Optional macro DEC_TAG_EN: one extra encrypted tag byte per frame, compared
// against the XOR of the frame's plaintext bytes and reported on tag_ok.

// Grain-style keystream core: 80-bit LFSR plus NFSR, output combinational.
module grain #(
    parameter int SEED_W = 105
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              Par_load,
    input  logic [SEED_W-1:0] Seed,
    output logic              out
);
    localparam int NW = SEED_W - 80;

    logic [79:0]   lfsr_reg;
    logic [NW-1:0] nfsr_reg;
    logic          lfsr_fb;
    logic          nfsr_fb;

    assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[13] ^ lfsr_reg[23]
                   ^ lfsr_reg[38] ^ lfsr_reg[51] ^ lfsr_reg[62];
    assign nfsr_fb = lfsr_reg[0] ^ nfsr_reg[0] ^ nfsr_reg[9] ^ nfsr_reg[14]
                   ^ (nfsr_reg[3] & nfsr_reg[20])
                   ^ (nfsr_reg[7] & nfsr_reg[11] & nfsr_reg[18]);
    assign out     = nfsr_reg[1] ^ nfsr_reg[6] ^ nfsr_reg[15] ^ lfsr_reg[3]
                   ^ (lfsr_reg[25] & nfsr_reg[12])
                   ^ (lfsr_reg[46] & lfsr_reg[64])
                   ^ (nfsr_reg[22] & lfsr_reg[10]);

    // Parallel load has priority over shifting; both registers step together.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= '0;
            nfsr_reg <= '0;
        end else if (Par_load) begin
            lfsr_reg <= Seed[79:0];
            nfsr_reg <= Seed[SEED_W-1:80];
        end else if (shift_en) begin
            lfsr_reg <= {lfsr_fb, lfsr_reg[79:1]};
            nfsr_reg <= {nfsr_fb, nfsr_reg[NW-1:1]};
        end
    end
endmodule

module grain_stream_decryptor #(
    parameter int SEED_W = 105,
    parameter int WARMUP = 160,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              cipher_bit,
    input  logic              cipher_valid,
    output logic              cipher_ready,
    output logic [7:0]        plain_byte,
    output logic              plain_valid,
    output logic              busy,
    output logic              done,
    output logic              tag_ok
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WARM = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int               WCNT_W  = $clog2(WARMUP + 1);
    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP - 1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    logic [2:0]        state_reg, state_next;
    logic [SEED_W-1:0] seed_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  byte_cnt_reg;
    logic [WCNT_W-1:0] warm_cnt_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic [7:0]        plain_byte_reg;
    logic              plain_valid_reg;

    logic       ks_bit;
    logic       shift_en;
    logic       par_load;
    logic       accept;
    logic       plain_bit;
    logic [7:0] byte_next;
    logic       byte_end;
    logic       data_byte_end;
    logic       last_data_byte;
    logic       frame_end;
    logic       warm_last;
    logic       len_zero;
    logic       start_ok;

    grain #(.SEED_W(SEED_W)) u_grain (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .Par_load (par_load),
        .Seed     (seed_reg),
        .out      (ks_bit)
    );

    assign start_ok       = (state_reg == S_IDLE) && start;
    assign accept         = (state_reg == S_RUN) && cipher_valid;
    assign par_load       = (state_reg == S_LOAD);
    // Keystream advances through warm-up and only on accepted bits afterwards,
    // so idle gaps on the link never consume keystream.
    assign shift_en       = (state_reg == S_WARM) || accept;
    assign plain_bit      = cipher_bit ^ ks_bit;
    assign byte_next      = {shift_reg[6:0], plain_bit};
    assign byte_end       = accept && (bit_cnt_reg == 3'd7);
    assign last_data_byte = (byte_cnt_reg == len_reg - LEN_ONE);
    assign warm_last      = (warm_cnt_reg == WARM_LAST);
    assign len_zero       = (len_reg == '0);

`ifdef DEC_TAG_EN
    logic       tag_phase_reg;
    logic [7:0] xor_reg;
    logic       tag_ok_reg;

    assign data_byte_end = byte_end && !tag_phase_reg;
    assign frame_end     = byte_end && tag_phase_reg;
    assign tag_ok        = tag_ok_reg;

    // Tag phase follows the data bytes (or warm-up directly for empty frames).
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_phase_reg <= 1'b0;
            xor_reg       <= '0;
            tag_ok_reg    <= 1'b0;
        end else begin
            if (start_ok) begin
                tag_phase_reg <= 1'b0;
                xor_reg       <= '0;
                tag_ok_reg    <= 1'b0;
            end
            if ((state_reg == S_WARM) && warm_last)
                tag_phase_reg <= len_zero;
            if (data_byte_end) begin
                xor_reg <= xor_reg ^ byte_next;
                if (last_data_byte)
                    tag_phase_reg <= 1'b1;
            end
            if (frame_end)
                tag_ok_reg <= (byte_next == xor_reg);
        end
    end
`else
    assign data_byte_end = byte_end;
    assign frame_end     = byte_end && last_data_byte;
    assign tag_ok        = 1'b0;
`endif

    // Frame sequencing: load, warm-up, receive, single-cycle finish.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_WARM;
            S_WARM: begin
                if (warm_last) begin
`ifdef DEC_TAG_EN
                    state_next = S_RUN;
`else
                    state_next = len_zero ? S_FIN : S_RUN;
`endif
                end
            end
            S_RUN:  if (frame_end) state_next = S_FIN;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, counters and byte assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            seed_reg        <= '0;
            len_reg         <= '0;
            byte_cnt_reg    <= '0;
            warm_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            plain_byte_reg  <= '0;
            plain_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            plain_valid_reg <= 1'b0;
            if (start_ok) begin
                seed_reg     <= seed;
                len_reg      <= msg_len;
                byte_cnt_reg <= '0;
                warm_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end
            if (state_reg == S_WARM)
                warm_cnt_reg <= warm_cnt_reg + 1'b1;
            if (accept) begin
                shift_reg   <= byte_next;
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (data_byte_end) begin
                plain_byte_reg  <= byte_next;
                plain_valid_reg <= 1'b1;
                byte_cnt_reg    <= byte_cnt_reg + 1'b1;
            end
        end
    end

    assign cipher_ready = (state_reg == S_RUN);
    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_FIN);
    assign plain_byte   = plain_byte_reg;
    assign plain_valid  = plain_valid_reg;
endmodule

// File: tb/tb_grain_stream_decryptor.sv
// Self-checking bench for grain_stream_decryptor: an independent keystream
// model encrypts known bytes, expected plaintext goes to a scoreboard queue,
// and a monitor pops it on every plain_valid pulse.
module tb_grain_stream_decryptor;
    localparam int SEED_W = 105;
    localparam int WARMUP = 160;
    localparam int LEN_W  = 16;
    localparam logic [SEED_W-1:0] SEED_A = 105'habcdef123abc12345ab6789cde;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [SEED_W-1:0] seed;
    logic [LEN_W-1:0]  msg_len;
    logic              cipher_bit;
    logic              cipher_valid;
    logic              cipher_ready;
    logic [7:0]        plain_byte;
    logic              plain_valid;
    logic              busy;
    logic              done;
    logic              tag_ok;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int shift_cnt = 0;
    int pv_cnt    = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  frame_bytes [2];
    logic [79:0] ml;
    logic [24:0] mn;

    always #5 clk = ~clk;

    grain_stream_decryptor #(.SEED_W(SEED_W), .WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .msg_len      (msg_len),
        .cipher_bit   (cipher_bit),
        .cipher_valid (cipher_valid),
        .cipher_ready (cipher_ready),
        .plain_byte   (plain_byte),
        .plain_valid  (plain_valid),
        .busy         (busy),
        .done         (done),
        .tag_ok       (tag_ok)
    );

    // Cycle counter and count of keystream shifts issued to the grain core.
    always @(posedge clk) begin
        cyc++;
        if (dut.shift_en) shift_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every plain_valid pulse must match the queue head.
    always @(negedge clk) begin
        if (plain_valid) begin
            pv_cnt++;
            chk("plain_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("plain_byte", 32'(plain_byte), 32'(e));
                $display("byte out: %02h (expected %02h) at cycle %0d", plain_byte, e, cyc);
            end
        end
    end

    // Reference keystream generator.
    function automatic logic m_out();
        return mn[1] ^ mn[6] ^ mn[15] ^ ml[3] ^ (ml[25] & mn[12])
             ^ (ml[46] & ml[64]) ^ (mn[22] & ml[10]);
    endfunction

    task automatic m_shift();
        logic lf, nf;
        lf = ml[0] ^ ml[13] ^ ml[23] ^ ml[38] ^ ml[51] ^ ml[62];
        nf = ml[0] ^ mn[0] ^ mn[9] ^ mn[14] ^ (mn[3] & mn[20]) ^ (mn[7] & mn[11] & mn[18]);
        ml = {lf, ml[79:1]};
        mn = {nf, mn[24:1]};
    endtask

    task automatic m_prime(input logic [SEED_W-1:0] s);
        ml = s[79:0];
        mn = s[104:80];
        repeat (WARMUP) m_shift();
    endtask

    // Start a frame; returns cycle stamp after the start edge and shift base.
    task automatic kick(input logic [SEED_W-1:0] s, input int n, output int t0, output int s0);
        @(negedge clk);
        seed    = s;
        msg_len = LEN_W'(n);
        start   = 1'b1;
        s0      = shift_cnt;
        @(negedge clk);
        t0    = cyc;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_ready(input int t0);
        int w;
        w = 0;
        while (!cipher_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("ready_latency", 32'(cyc - t0), 32'(WARMUP + 1));
    endtask

    task automatic send_bit(input logic c, input int gap);
        for (int g = 0; g < gap; g++) begin
            cipher_valid = 1'b0;
            cipher_bit   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        cipher_valid = 1'b1;
        cipher_bit   = c;
        @(negedge clk);
    endtask

    // Full frame of n bytes from frame_bytes (plus a tag byte when enabled).
    task automatic run_frame(input logic [SEED_W-1:0] s, input int n, input int gap, input logic corrupt);
        int t0, s0, nb;
        logic [7:0] p, xacc;
        nb   = n;
`ifdef DEC_TAG_EN
        nb   = n + 1;
`endif
        xacc = 8'h00;
        m_prime(s);
        kick(s, n, t0, s0);
        wait_ready(t0);
        for (int bi = 0; bi < nb; bi++) begin
            if (bi < n) begin
                p = frame_bytes[bi];
                exp_q.push_back(p);
                xacc = xacc ^ p;
            end else begin
                p = xacc ^ {7'b0, corrupt};
            end
            for (int k = 7; k >= 0; k--) begin
                logic ks;
                ks = m_out();
                m_shift();
                send_bit(p[k] ^ ks, gap);
            end
        end
        cipher_valid = 1'b0;
        chk("done_after_last", 32'(done), 32'd1);
        chk("ready_drop_after_last", 32'(cipher_ready), 32'd0);
`ifdef DEC_TAG_EN
        chk("tag_ok_in_fin", 32'(tag_ok), 32'(!corrupt));
`endif
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("idle_after_fin", 32'(busy), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("shift_count", 32'(shift_cnt - s0), 32'(WARMUP + 8 * nb));
`ifdef DEC_TAG_EN
        chk("tag_ok_held", 32'(tag_ok), 32'(!corrupt));
`endif
        $display("frame done: len=%0d gap=%0d corrupt=%0d shifts=%0d", n, gap, corrupt, shift_cnt - s0);
    endtask

    initial begin
        int t0, s0, busy_seen, ready_seen, done_seen, w;
        logic [7:0] p;
        frame_bytes[0] = 8'hA5;
        frame_bytes[1] = 8'h3C;
        rst = 1'b1; start = 1'b0; seed = '0; msg_len = '0;
        cipher_bit = 1'b0; cipher_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cipher_ready), 32'd0);
        chk("rst_plain_valid", 32'(plain_valid), 32'd0);
        chk("rst_plain_byte", 32'(plain_byte), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tag_ok", 32'(tag_ok), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round trip with continuous valid.
        run_frame(SEED_A, 2, 0, 1'b0);
        chk("plain_byte_hold", 32'(plain_byte), 32'h3C);

        // Same frame with 3-cycle gaps before every bit.
        run_frame(SEED_A, 2, 3, 1'b0);

        // Reset mid-RUN after five bits, then replay the frame.
        m_prime(SEED_A);
        kick(SEED_A, 2, t0, s0);
        wait_ready(t0);
        p = frame_bytes[0];
        for (int k = 7; k >= 3; k--) begin
            logic ks;
            ks = m_out();
            m_shift();
            send_bit(p[k] ^ ks, 0);
        end
        cipher_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_ready", 32'(cipher_ready), 32'd0);
        chk("midrun_rst_plain_valid", 32'(plain_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(SEED_A, 2, 0, 1'b0);

`ifdef DEC_TAG_EN
        run_frame(SEED_A, 2, 0, 1'b1);
        run_frame(SEED_A ^ 105'h5a5a, 0, 0, 1'b0);
        chk("plain_valid_total", 32'(pv_cnt), 32'd8);
`else
        // Empty frame; a start pulse during warm-up must be ignored.
        kick(SEED_A, 0, t0, s0);
        w = 0; ready_seen = 0;
        while (!done && w < 400) begin
            @(negedge clk);
            w++;
            start = (w == 10);
            if (cipher_ready) ready_seen = 1;
        end
        start = 1'b0;
        chk("zero_len_done_latency", 32'(cyc - t0), 32'(WARMUP + 1));
        chk("zero_len_shifts", 32'(shift_cnt - s0), 32'(WARMUP));
        busy_seen = 0; done_seen = 0;
        @(negedge clk);
        repeat (200) begin
            if (busy) busy_seen = 1;
            if (done) done_seen = 1;
            if (cipher_ready) ready_seen = 1;
            @(negedge clk);
        end
        chk("zero_len_no_ready", 32'(ready_seen), 32'd0);
        chk("start_while_busy_ignored", 32'(busy_seen), 32'd0);
        chk("no_second_done", 32'(done_seen), 32'd0);
        chk("tag_ok_tied_low", 32'(tag_ok), 32'd0);
        chk("plain_valid_total", 32'(pv_cnt), 32'd6);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
